// File: rtl/frac_clken_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// frac_clk_pkg
//   Shared definitions for the fractional clock-enable generator.
//   - ACC_W_MAX : widest supported accumulator / step word
//   - ch_w()    : channel-select width for a given channel count (min 1 bit)
//   - chan_cfg_t: per-channel programming state (active step, shadow, flags)
//   - step_for(): step word that yields f_ce_hz from f_src_hz, for benches and
//                 top-level constants only (elaboration/simulation time)
// -----------------------------------------------------------------------------
package frac_clk_pkg;

  localparam int ACC_W_MAX = 32;

  // Width of the channel-select field; a single channel still gets one bit.
  function automatic int ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // Step and shadow are sized for the widest accumulator; narrower channels
  // use the low ACC_W bits and keep the rest at zero.
  typedef struct packed {
    logic [ACC_W_MAX-1:0] step;    // step used by the accumulator now
    logic [ACC_W_MAX-1:0] shadow;  // step waiting for the next wrap
    logic                 pend;    // shadow holds an unapplied step
    logic                 en;      // channel is running
  } chan_cfg_t;

  // f_ce = f_src * step / 2^acc_w  =>  step = round(f_ce / f_src * 2^acc_w)
  function automatic longint step_for(input real f_src_hz, input real f_ce_hz,
                                      input int acc_w);
    return longint'(f_ce_hz / f_src_hz * (2.0 ** acc_w));
  endfunction

endpackage

// File: rtl/frac_clken_ctrl_if.sv
// -----------------------------------------------------------------------------
// frac_clken_ctrl_if
//   Configuration bus into the clock-enable generator (clk_src domain).
//   cfg_wr   : one-cycle write strobe, no backpressure
//   cfg_ch   : target channel; values >= N_CH select nothing
//   cfg_step : new step word
//   cfg_en   : 1 = run the channel with cfg_step, 0 = stop it
//   cfg_sync : one-cycle pulse that phase-aligns every channel
//   Modports: master drives the bus, slave (the generator) receives it.
// -----------------------------------------------------------------------------
interface frac_clken_ctrl_if
  import frac_clk_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int ACC_W = 32
);

  localparam int CH_W = ch_w(N_CH);

  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_step;
  logic             cfg_en;
  logic             cfg_sync;

  modport master (
    output cfg_wr,
    output cfg_ch,
    output cfg_step,
    output cfg_en,
    output cfg_sync
  );

  modport slave (
    input cfg_wr,
    input cfg_ch,
    input cfg_step,
    input cfg_en,
    input cfg_sync
  );

endinterface

// File: rtl/frac_clken_ctrl_chan.sv
// -----------------------------------------------------------------------------
// frac_acc_chan
//   One phase-accumulator channel. Each enabled cycle adds the step word to the
//   accumulator; the carry out of the add becomes a one-cycle enable pulse and
//   toggles the square-wave output. Step changes on a running channel are held
//   in a shadow register and applied at the next wrap so the output never sees
//   a partial period.
//   Ports:
//     clk_src   : source clock
//     reset     : synchronous active-high reset
//     wr_i      : write strobe addressed to this channel
//     wr_en_i   : 1 = run with wr_step_i, 0 = stop the channel
//     wr_step_i : step word carried by the write
//     sync_i    : phase-align pulse (accumulator and clock level cleared)
//     ce_o      : registered enable pulse, high the cycle after a wrap
//     clk_o     : registered square wave, toggles on each wrap
//     pend_o    : a step update is waiting for the next wrap
// -----------------------------------------------------------------------------
module frac_acc_chan
  import frac_clk_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic             clk_src,
  input  logic             reset,
  input  logic             wr_i,
  input  logic             wr_en_i,
  input  logic [ACC_W-1:0] wr_step_i,
  input  logic             sync_i,
  output logic             ce_o,
  output logic             clk_o,
  output logic             pend_o
);

  chan_cfg_t        cfg_q, cfg_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             clk_q, clk_d;
  logic             ce_q,  ce_d;
  logic [ACC_W:0]   sum;

  // One extra bit on the add captures the wrap as the carry.
  assign sum = {1'b0, acc_q} + {1'b0, cfg_q.step[ACC_W-1:0]};

  // The three sources of change are layered in priority order: the normal
  // accumulate, then a write, then sync. Later layers read the values the
  // earlier layers produced, so a write landing with sync is already visible
  // to sync (its step applies immediately, a disable stays disabled).
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    cfg_d = cfg_q;
    acc_d = acc_q;
    clk_d = clk_q;
    ce_d  = 1'b0;

    if (cfg_q.en) begin
      acc_d = sum[ACC_W-1:0];
      if (sum[ACC_W]) begin
        ce_d  = 1'b1;
        clk_d = ~clk_q;
        // The wrap that just happened used the old step; the shadow takes
        // over from the next add.
        if (cfg_q.pend) begin
          cfg_d.step = cfg_q.shadow;
          cfg_d.pend = 1'b0;
        end
      end
    end

    if (wr_i) begin
      if (!wr_en_i) begin
        // Stop: everything quiet from the next cycle, step kept for later.
        cfg_d.en   = 1'b0;
        cfg_d.pend = 1'b0;
        cfg_d.step = ACC_W_MAX'(wr_step_i);
        acc_d      = '0;
        clk_d      = 1'b0;
        ce_d       = 1'b0;
      end else if (cfg_q.en) begin
        // Running: park the step until the next wrap. Coming after the
        // accumulate layer, a write on a wrap edge re-arms pend and waits
        // for the following wrap; repeated writes just overwrite the shadow.
        cfg_d.shadow = ACC_W_MAX'(wr_step_i);
        cfg_d.pend   = 1'b1;
      end else begin
        // Stopped: start from phase zero with the new step right away.
        cfg_d.en   = 1'b1;
        cfg_d.pend = 1'b0;
        cfg_d.step = ACC_W_MAX'(wr_step_i);
        acc_d      = '0;
      end
    end

    if (sync_i) begin
      acc_d = '0;
      clk_d = 1'b0;
      ce_d  = 1'b0;
      if (cfg_d.pend) begin
        cfg_d.step = cfg_d.shadow;
        cfg_d.pend = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_src) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      cfg_q <= '0;
      acc_q <= '0;
      clk_q <= 1'b0;
      ce_q  <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      acc_q <= acc_d;
      clk_q <= clk_d;
      ce_q  <= ce_d;
    end
  end

  assign ce_o   = ce_q;
  assign clk_o  = clk_q;
  assign pend_o = cfg_q.pend;

  // With a narrow accumulator the upper step/shadow bits are always zero and
  // never read by the datapath.
  if (ACC_W < ACC_W_MAX) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^{cfg_q.step[ACC_W_MAX-1:ACC_W],
                         cfg_q.shadow[ACC_W_MAX-1:ACC_W]};
  end

endmodule

// File: rtl/frac_clken_ctrl.sv
// -----------------------------------------------------------------------------
// frac_clken_ctrl
//   Multi-channel runtime-programmable fractional clock-enable generator.
//   Each channel is a phase accumulator producing f_ce = f_src*step/2^ACC_W
//   enable pulses and a square wave at f_ce/2, all in the clk_src domain.
//   This level decodes the configuration channel select and fans the sync
//   pulse out to every channel.
//   Ports:
//     clk_src : source clock, the only clock
//     reset   : synchronous active-high reset
//     cfg     : configuration bus (slave side of frac_clken_ctrl_if)
//     ce_o    : per-channel one-cycle enable pulses
//     clk_o   : per-channel square waves, toggling on each ce
//     pend_o  : per-channel step update pending
// -----------------------------------------------------------------------------
module frac_clken_ctrl
  import frac_clk_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int ACC_W = 32
) (
  input  logic              clk_src,
  input  logic              reset,
  frac_clken_ctrl_if.slave  cfg,
  output logic [N_CH-1:0]   ce_o,
  output logic [N_CH-1:0]   clk_o,
  output logic [N_CH-1:0]   pend_o
);

  localparam int CH_W = ch_w(N_CH);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Only indices below N_CH exist, so an out-of-range select matches no
    // channel and the write is dropped.
    logic wr_hit;
    assign wr_hit = cfg.cfg_wr && (cfg.cfg_ch == CH_W'(i));

    frac_acc_chan #(
      .ACC_W (ACC_W)
    ) u_chan (
      .clk_src   (clk_src),
      .reset     (reset),
      .wr_i      (wr_hit),
      .wr_en_i   (cfg.cfg_en),
      .wr_step_i (cfg.cfg_step),
      .sync_i    (cfg.cfg_sync),
      .ce_o      (ce_o[i]),
      .clk_o     (clk_o[i]),
      .pend_o    (pend_o[i])
    );
  end

endmodule

// File: tb/tb_frac_clken_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frac_clken_ctrl
//   Directed bench for frac_clken_ctrl with N_CH=5 (so channel selects 5..7
//   are out of range) and ACC_W=8. Edge numbering in comments: E0 is the edge
//   on which a write or sync is sampled; outputs are read 1 ns after an edge.
// -----------------------------------------------------------------------------
module tb_frac_clken_ctrl;
  import frac_clk_pkg::*;

  localparam int N_CH  = 5;
  localparam int ACC_W = 8;
  localparam int CH_W  = 3;

  logic            clk_src = 1'b0;
  logic            reset;
  logic [N_CH-1:0] ce_o, clk_o, pend_o;

  int total = 0;
  int bad   = 0;

  frac_clken_ctrl_if #(.N_CH(N_CH), .ACC_W(ACC_W)) bus ();

  frac_clken_ctrl #(.N_CH(N_CH), .ACC_W(ACC_W)) dut (
    .clk_src (clk_src),
    .reset   (reset),
    .cfg     (bus),
    .ce_o    (ce_o),
    .clk_o   (clk_o),
    .pend_o  (pend_o)
  );

  always #5 clk_src = ~clk_src;

  task automatic tick();
    @(posedge clk_src);
    #1;
  endtask

  // One-edge configuration access; wr and sync drop again after the edge.
  task automatic cfg(input int ch, input int step, input logic en, input logic sync);
    bus.cfg_wr   = 1'b1;
    bus.cfg_ch   = CH_W'(ch);
    bus.cfg_step = ACC_W'(step);
    bus.cfg_en   = en;
    bus.cfg_sync = sync;
    tick();
    bus.cfg_wr   = 1'b0;
    bus.cfg_sync = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++; if (ce_o !== '0) begin bad++; $display("FAIL reset_ce got=%b want=%b", ce_o, 5'b0); end
    total++; if (clk_o !== '0) begin bad++; $display("FAIL reset_clk got=%b want=%b", clk_o, 5'b0); end
    total++; if (pend_o !== '0) begin bad++; $display("FAIL reset_pend got=%b want=%b", pend_o, 5'b0); end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (ce_o !== '0) begin bad++; $display("FAIL reset_idle k=%0d got=%b want=%b", k, ce_o, 5'b0); end
    end
  endtask

  // ch0 step 0x80: ce every 2nd edge, first at E2; clk_o period 4.
  task automatic test_basic();
    logic [ACC_W-1:0] half;
    logic [N_CH-1:0]  exp_ce, exp_clk;
    half = ACC_W'(step_for(256.0, 128.0, ACC_W));
    cfg(0, int'(half), 1'b1, 1'b0);
    total++; if (ce_o !== '0) begin bad++; $display("FAIL basic_e0 got=%b want=%b", ce_o, 5'b0); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_ce  = (k % 2 == 0) ? 5'b00001 : 5'b00000;
      exp_clk = ((k / 2) % 2 == 1) ? 5'b00001 : 5'b00000;
      total++; if (ce_o !== exp_ce) begin bad++; $display("FAIL basic_ce k=%0d got=%b want=%b", k, ce_o, exp_ce); end
      total++; if (clk_o !== exp_clk) begin bad++; $display("FAIL basic_clk k=%0d got=%b want=%b", k, clk_o, exp_clk); end
      total++; if (pend_o !== '0) begin bad++; $display("FAIL basic_pend k=%0d got=%b want=%b", k, pend_o, 5'b0); end
    end
    // Step 0 scheduled at E9, committed by the wrap at E10; clk_o then holds 1.
    cfg(0, 0, 1'b1, 1'b0);
    total++; if (pend_o !== 5'b00001) begin bad++; $display("FAIL step0_pend got=%b want=%b", pend_o, 5'b00001); end
    tick();
    total++; if (ce_o !== 5'b00001) begin bad++; $display("FAIL step0_last_ce got=%b want=%b", ce_o, 5'b00001); end
    total++; if (pend_o !== '0) begin bad++; $display("FAIL step0_pend_clr got=%b want=%b", pend_o, 5'b0); end
    for (int k = 0; k < 8; k++) begin
      tick();
      total++; if (ce_o !== '0) begin bad++; $display("FAIL step0_ce k=%0d got=%b want=%b", k, ce_o, 5'b0); end
      total++; if (clk_o !== 5'b00001) begin bad++; $display("FAIL step0_hold k=%0d got=%b want=%b", k, clk_o, 5'b00001); end
    end
    cfg(0, 0, 1'b0, 1'b0);
    total++; if (clk_o !== '0) begin bad++; $display("FAIL basic_off got=%b want=%b", clk_o, 5'b0); end
  endtask

  // ch0 step 0x55: wraps on additions 4, 7, 10; 772*0x55 = 65620 -> 256 wraps.
  // Then step 0xFF: 256 additions wrap 255 times (only the first misses).
  task automatic test_frac();
    int   cnt;
    logic exp_bit;
    cfg(0, 'h55, 1'b1, 1'b0);
    cnt = 0;
    for (int n = 1; n <= 772; n++) begin
      tick();
      if (ce_o[0] === 1'b1) cnt++;
      if (n <= 12) begin
        exp_bit = (n == 4 || n == 7 || n == 10);
        total++; if (ce_o[0] !== exp_bit) begin bad++; $display("FAIL frac_ce n=%0d got=%b want=%b", n, ce_o[0], exp_bit); end
      end
    end
    total++; if (cnt != 256) begin bad++; $display("FAIL frac_count got=%0d want=%0d", cnt, 256); end
    cfg(0, 0, 1'b0, 1'b0);
    cfg(0, 'hFF, 1'b1, 1'b0);
    cnt = 0;
    for (int n = 1; n <= 256; n++) begin
      tick();
      if (ce_o[0] === 1'b1) cnt++;
    end
    total++; if (cnt != 255) begin bad++; $display("FAIL max_step_count got=%0d want=%0d", cnt, 255); end
    cfg(0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_update();
    logic [N_CH-1:0] exp_ce;
    // ch1 at 0x40: wrap at E4.
    cfg(1, 'h40, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_ce = (k == 4) ? 5'b00010 : 5'b00000;
      total++; if (ce_o !== exp_ce) begin bad++; $display("FAIL upd_old k=%0d got=%b want=%b", k, ce_o, exp_ce); end
    end
    // 0x80 written at E6 (acc 0x40 -> 0x80), old step wraps at E8.
    cfg(1, 'h80, 1'b1, 1'b0);
    total++; if (pend_o !== 5'b00010) begin bad++; $display("FAIL upd_pend_e6 got=%b want=%b", pend_o, 5'b00010); end
    tick();
    total++; if (ce_o !== '0 || pend_o !== 5'b00010) begin bad++; $display("FAIL upd_e7 got=%b/%b want=%b/%b", ce_o, pend_o, 5'b0, 5'b00010); end
    tick();
    total++; if (ce_o !== 5'b00010) begin bad++; $display("FAIL upd_wrap_e8 got=%b want=%b", ce_o, 5'b00010); end
    total++; if (pend_o !== '0) begin bad++; $display("FAIL upd_pend_e8 got=%b want=%b", pend_o, 5'b0); end
    for (int k = 9; k <= 12; k++) begin
      tick();
      exp_ce = (k % 2 == 0) ? 5'b00010 : 5'b00000;
      total++; if (ce_o !== exp_ce) begin bad++; $display("FAIL upd_new k=%0d got=%b want=%b", k, ce_o, exp_ce); end
    end
    cfg(1, 0, 1'b0, 1'b0);

    // Two writes before the wrap: 0x10 then 0x80; only 0x80 is used.
    cfg(1, 'h40, 1'b1, 1'b0);
    cfg(1, 'h10, 1'b1, 1'b0);
    cfg(1, 'h80, 1'b1, 1'b0);
    total++; if (pend_o !== 5'b00010) begin bad++; $display("FAIL dbl_pend got=%b want=%b", pend_o, 5'b00010); end
    tick();
    total++; if (ce_o !== '0) begin bad++; $display("FAIL dbl_e3 got=%b want=%b", ce_o, 5'b0); end
    tick();
    total++; if (ce_o !== 5'b00010 || pend_o !== '0) begin bad++; $display("FAIL dbl_e4 got=%b/%b want=%b/%b", ce_o, pend_o, 5'b00010, 5'b0); end
    tick();
    total++; if (ce_o !== '0) begin bad++; $display("FAIL dbl_e5 got=%b want=%b", ce_o, 5'b0); end
    tick();
    total++; if (ce_o !== 5'b00010) begin bad++; $display("FAIL dbl_e6 got=%b want=%b", ce_o, 5'b00010); end
    tick();
    // Write 0x40 on the wrap edge E8: it waits for the wrap at E10.
    cfg(1, 'h40, 1'b1, 1'b0);
    total++; if (ce_o !== 5'b00010 || pend_o !== 5'b00010) begin bad++; $display("FAIL same_edge_e8 got=%b/%b want=%b/%b", ce_o, pend_o, 5'b00010, 5'b00010); end
    tick();
    total++; if (ce_o !== '0 || pend_o !== 5'b00010) begin bad++; $display("FAIL same_edge_e9 got=%b/%b want=%b/%b", ce_o, pend_o, 5'b0, 5'b00010); end
    tick();
    total++; if (ce_o !== 5'b00010 || pend_o !== '0) begin bad++; $display("FAIL same_edge_e10 got=%b/%b want=%b/%b", ce_o, pend_o, 5'b00010, 5'b0); end
    for (int k = 11; k <= 14; k++) begin
      tick();
      exp_ce = (k == 14) ? 5'b00010 : 5'b00000;
      total++; if (ce_o !== exp_ce) begin bad++; $display("FAIL same_edge_after k=%0d got=%b want=%b", k, ce_o, exp_ce); end
    end
    cfg(1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_sync();
    logic [N_CH-1:0] exp_ce;
    cfg(0, 'h40, 1'b1, 1'b0);
    cfg(1, 'h20, 1'b1, 1'b0);
    cfg(2, 'h10, 1'b1, 1'b0);
    for (int k = 0; k < 13; k++) tick();
    // Sync together with enabling stopped ch3 at 0x80.
    cfg(3, 'h80, 1'b1, 1'b1);
    total++; if (clk_o !== '0) begin bad++; $display("FAIL sync_clk got=%b want=%b", clk_o, 5'b0); end
    total++; if (ce_o !== '0) begin bad++; $display("FAIL sync_ce got=%b want=%b", ce_o, 5'b0); end
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_ce = {1'b0, k % 2 == 0, k % 16 == 0, k % 8 == 0, k % 4 == 0};
      total++; if (ce_o !== exp_ce) begin bad++; $display("FAIL sync_align k=%0d got=%b want=%b", k, ce_o, exp_ce); end
    end
    total++; if (clk_o !== 5'b00100) begin bad++; $display("FAIL sync_clk16 got=%b want=%b", clk_o, 5'b00100); end
    // Write to running ch0 on a sync edge: step 0x80 takes effect at once.
    cfg(0, 'h80, 1'b1, 1'b1);
    total++; if (pend_o !== '0 || ce_o !== '0) begin bad++; $display("FAIL sync_wr got=%b/%b want=%b/%b", pend_o, ce_o, 5'b0, 5'b0); end
    tick();
    total++; if (ce_o !== '0) begin bad++; $display("FAIL sync_wr_e1 got=%b want=%b", ce_o, 5'b0); end
    tick();
    total++; if (ce_o !== 5'b01001) begin bad++; $display("FAIL sync_wr_e2 got=%b want=%b", ce_o, 5'b01001); end
    // Disable on a sync edge stays disabled.
    cfg(3, 0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (ce_o[3] !== 1'b0 || clk_o[3] !== 1'b0) begin bad++; $display("FAIL sync_off k=%0d got=%b/%b want=0/0", k, ce_o[3], clk_o[3]); end
    end
    for (int c = 0; c < 3; c++) cfg(c, 0, 1'b0, 1'b0);
  endtask

  task automatic test_range_disable();
    cfg(0, 'h80, 1'b1, 1'b0);
    tick();
    cfg(5, 'h10, 1'b0, 1'b0);   // E2, out of range: ch0 keeps wrapping
    total++; if (ce_o !== 5'b00001) begin bad++; $display("FAIL range_e2 got=%b want=%b", ce_o, 5'b00001); end
    tick();
    total++; if (ce_o !== '0) begin bad++; $display("FAIL range_e3 got=%b want=%b", ce_o, 5'b0); end
    tick();
    total++; if (ce_o !== 5'b00001) begin bad++; $display("FAIL range_e4 got=%b want=%b", ce_o, 5'b00001); end
    cfg(7, 'h10, 1'b1, 1'b0);   // E5, out of range
    total++; if (pend_o !== '0 || ce_o !== '0) begin bad++; $display("FAIL range_e5 got=%b/%b want=%b/%b", pend_o, ce_o, 5'b0, 5'b0); end
    tick();
    total++; if (ce_o !== 5'b00001 || clk_o !== 5'b00001) begin bad++; $display("FAIL range_e6 got=%b/%b want=%b/%b", ce_o, clk_o, 5'b00001, 5'b00001); end
    cfg(0, 'h80, 1'b0, 1'b0);   // E7 disable
    total++; if (ce_o !== '0 || clk_o !== '0) begin bad++; $display("FAIL dis_e7 got=%b/%b want=%b/%b", ce_o, clk_o, 5'b0, 5'b0); end
    tick();
    total++; if (ce_o !== '0) begin bad++; $display("FAIL dis_e8 got=%b want=%b", ce_o, 5'b0); end
    cfg(0, 'h80, 1'b1, 1'b0);   // E9 re-enable from acc=0
    tick();
    total++; if (ce_o !== '0) begin bad++; $display("FAIL reen_e10 got=%b want=%b", ce_o, 5'b0); end
    tick();
    total++; if (ce_o !== 5'b00001 || clk_o !== 5'b00001) begin bad++; $display("FAIL reen_e11 got=%b/%b want=%b/%b", ce_o, clk_o, 5'b00001, 5'b00001); end
    cfg(0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    cfg(1, 'h40, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    cfg(1, 'h80, 1'b1, 1'b0);   // E5: pending, clk_o[1] high since E4
    total++; if (pend_o !== 5'b00010 || clk_o !== 5'b00010) begin bad++; $display("FAIL rmid_pre got=%b/%b want=%b/%b", pend_o, clk_o, 5'b00010, 5'b00010); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (ce_o !== '0 || clk_o !== '0 || pend_o !== '0) begin bad++; $display("FAIL rmid_clear got=%b/%b/%b want=0/0/0", ce_o, clk_o, pend_o); end
    for (int k = 0; k < 10; k++) begin
      tick();
      total++; if (ce_o !== '0 || clk_o !== '0) begin bad++; $display("FAIL rmid_idle k=%0d got=%b/%b want=0/0", k, ce_o, clk_o); end
    end
    cfg(1, 'h80, 1'b1, 1'b0);
    tick(); tick();
    total++; if (ce_o !== 5'b00010) begin bad++; $display("FAIL rmid_restart got=%b want=%b", ce_o, 5'b00010); end
  endtask

  initial begin
    reset        = 1'b1;
    bus.cfg_wr   = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_step = '0;
    bus.cfg_en   = 1'b0;
    bus.cfg_sync = 1'b0;
    test_reset();
    test_basic();
    test_frac();
    test_update();
    test_sync();
    test_range_disable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
